// File: rtl/button_debounce_repeat_pkg.sv
// Shared definitions for the push-button front end: channel states, key indices,
// default timing constants and small elaboration helpers.
package button_debounce_repeat_pkg;

   typedef enum logic [2:0] {
      ST_ARM        = 3'd0,
      ST_IDLE       = 3'd1,
      ST_DB_PRESS   = 3'd2,
      ST_PRESSED    = 3'd3,
      ST_DB_RELEASE = 3'd4
   } chan_state_t;

   localparam int BTN_PREV   = 0;
   localparam int BTN_NEXT   = 1;
   localparam int BTN_OK     = 2;
   localparam int BTN_CANCEL = 3;

   localparam int DEF_N_BUTTONS           = 4;
   localparam int DEF_DEBOUNCE_CYCLES     = 500000;
   localparam int DEF_REPEAT_DELAY_CYCLES = 25000000;
   localparam int DEF_REPEAT_RATE_CYCLES  = 5000000;
   localparam logic [3:0] DEF_REPEAT_MASK = 4'b0011;

   // One counter width serves every timing constant so the counters never wrap.
   function automatic int cnt_width(input int a, input int b, input int c);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return (m < 2) ? 1 : $clog2(m);
   endfunction

   function automatic logic is_held(input chan_state_t s);
      return (s == ST_PRESSED) || (s == ST_DB_RELEASE);
   endfunction

endpackage

// File: rtl/button_debounce_repeat_channel_fsm.sv
// One key channel: 2-FF synchroniser, arm/debounce FSM and auto-repeat timer.
// pulse and level are next-cycle values; the top level registers them.
module button_debounce_repeat_channel_fsm
   import button_debounce_repeat_pkg::*;
#(
   parameter bit ACTIVE_LOW          = 1'b1,
   parameter int DEBOUNCE_CYCLES     = DEF_DEBOUNCE_CYCLES,
   parameter int REPEAT_DELAY_CYCLES = DEF_REPEAT_DELAY_CYCLES,
   parameter int REPEAT_RATE_CYCLES  = DEF_REPEAT_RATE_CYCLES,
   parameter bit REPEAT_EN           = 1'b0,
   parameter int CNT_W               = cnt_width(DEF_DEBOUNCE_CYCLES, DEF_REPEAT_DELAY_CYCLES,
                                                 DEF_REPEAT_RATE_CYCLES)
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   input  logic key,
   output logic pulse,
   output logic level
);

   localparam logic [CNT_W-1:0] DB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(REPEAT_DELAY_CYCLES - 1);
   localparam logic [CNT_W-1:0] RATE_LAST  = CNT_W'(REPEAT_RATE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

   logic sync_meta;
   logic sync_key;
   logic pressed;

   chan_state_t state;
   chan_state_t state_next;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_next;
   logic [CNT_W-1:0] rcnt;
   logic [CNT_W-1:0] rcnt_next;
   logic repeating;
   logic repeating_next;

   // Synchroniser idles at the released level and keeps running while disabled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_meta <= ACTIVE_LOW;
         sync_key  <= ACTIVE_LOW;
      end else begin
         sync_meta <= key;
         sync_key  <= sync_meta;
      end
   end

   assign pressed = sync_key ^ ACTIVE_LOW;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_ARM;
         cnt       <= '0;
         rcnt      <= '0;
         repeating <= 1'b0;
      end else begin
         state     <= state_next;
         cnt       <= cnt_next;
         rcnt      <= rcnt_next;
         repeating <= repeating_next;
      end
   end

   // After the first repeat the timer reloads to 0 and compares against the rate instead.
   always_comb begin
      state_next     = state;
      cnt_next       = cnt;
      rcnt_next      = rcnt;
      repeating_next = repeating;
      pulse          = 1'b0;
      if (!en) begin
         state_next     = ST_ARM;
         cnt_next       = '0;
         rcnt_next      = '0;
         repeating_next = 1'b0;
      end else begin
         case (state)
            ST_ARM: begin
               if (pressed) begin
                  cnt_next = '0;
               end else if (cnt == DB_LAST) begin
                  state_next = ST_IDLE;
                  cnt_next   = '0;
               end else begin
                  cnt_next = cnt + CNT_ONE;
               end
            end
            ST_IDLE: begin
               if (pressed) begin
                  state_next = ST_DB_PRESS;
                  cnt_next   = '0;
               end
            end
            ST_DB_PRESS: begin
               if (!pressed) begin
                  state_next = ST_IDLE;
               end else if (cnt == DB_LAST) begin
                  state_next     = ST_PRESSED;
                  pulse          = 1'b1;
                  cnt_next       = '0;
                  rcnt_next      = '0;
                  repeating_next = 1'b0;
               end else begin
                  cnt_next = cnt + CNT_ONE;
               end
            end
            ST_PRESSED: begin
               if (!pressed) begin
                  state_next = ST_DB_RELEASE;
                  cnt_next   = '0;
               end else if (REPEAT_EN) begin
                  if (rcnt == (repeating ? RATE_LAST : DELAY_LAST)) begin
                     pulse          = 1'b1;
                     rcnt_next      = '0;
                     repeating_next = 1'b1;
                  end else begin
                     rcnt_next = rcnt + CNT_ONE;
                  end
               end
            end
            ST_DB_RELEASE: begin
               if (pressed) begin
                  state_next     = ST_PRESSED;
                  rcnt_next      = '0;
                  repeating_next = 1'b0;
               end else if (cnt == DB_LAST) begin
                  state_next = ST_IDLE;
                  cnt_next   = '0;
               end else begin
                  cnt_next = cnt + CNT_ONE;
               end
            end
            default: begin
               state_next     = ST_ARM;
               cnt_next       = '0;
               rcnt_next      = '0;
               repeating_next = 1'b0;
            end
         endcase
      end
   end

   assign level = is_held(state_next);

endmodule

// File: rtl/button_debounce_repeat.sv
// Front end for the menu push-buttons: per-key debounce/repeat channels feeding a
// lowest-index arbiter, so at most one press pulse leaves per clock.
module button_debounce_repeat
   import button_debounce_repeat_pkg::*;
#(
   parameter int N_BUTTONS                   = DEF_N_BUTTONS,
   parameter bit ACTIVE_LOW                  = 1'b1,
   parameter int DEBOUNCE_CYCLES             = DEF_DEBOUNCE_CYCLES,
   parameter int REPEAT_DELAY_CYCLES         = DEF_REPEAT_DELAY_CYCLES,
   parameter int REPEAT_RATE_CYCLES          = DEF_REPEAT_RATE_CYCLES,
   parameter logic [N_BUTTONS-1:0] REPEAT_MASK = N_BUTTONS'(DEF_REPEAT_MASK)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 en,
   input  logic [N_BUTTONS-1:0] iButton,
   output logic [N_BUTTONS-1:0] oButton,
   output logic [N_BUTTONS-1:0] oLevel
);

   localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY_CYCLES, REPEAT_RATE_CYCLES);

   logic [N_BUTTONS-1:0] raw_pulse;
   logic [N_BUTTONS-1:0] level_next;
   logic [N_BUTTONS-1:0] grant;

   for (genvar g = 0; g < N_BUTTONS; g++) begin : g_chan
      button_debounce_repeat_channel_fsm #(
         .ACTIVE_LOW          (ACTIVE_LOW),
         .DEBOUNCE_CYCLES     (DEBOUNCE_CYCLES),
         .REPEAT_DELAY_CYCLES (REPEAT_DELAY_CYCLES),
         .REPEAT_RATE_CYCLES  (REPEAT_RATE_CYCLES),
         .REPEAT_EN           (REPEAT_MASK[g]),
         .CNT_W               (CNT_W)
      ) u_chan (
         .clk   (clk),
         .rst_n (rst_n),
         .en    (en),
         .key   (iButton[g]),
         .pulse (raw_pulse[g]),
         .level (level_next[g])
      );
   end

   // Simultaneous pulses from higher-index keys are dropped, not queued.
   always_comb begin
      logic found;
      grant = '0;
      found = 1'b0;
      for (int i = 0; i < N_BUTTONS; i++) begin
         if (raw_pulse[i] && !found) begin
            grant[i] = 1'b1;
            found    = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         oButton <= '0;
         oLevel  <= '0;
      end else begin
         oButton <= en ? grant : '0;
         oLevel  <= en ? level_next : '0;
      end
   end

endmodule

// File: tb/tb_button_debounce_repeat.sv
// Self-checking bench: directed scenarios plus randomized key traffic compared
// against a run-length reference model of debounce, arming and auto-repeat.
module tb_button_debounce_repeat;

   localparam int NB    = 4;
   localparam int DB    = 4;
   localparam int DELAY = 20;
   localparam int RATE  = 8;
   localparam logic [NB-1:0] MASK = 4'b0011;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic en    = 1'b0;
   logic [NB-1:0] press = '0;
   logic [NB-1:0] iButton;
   logic [NB-1:0] oButton;
   logic [NB-1:0] oLevel;

   int checks = 0;
   int fails  = 0;

   assign iButton = ~press;

   always #5 clk = ~clk;

   button_debounce_repeat #(
      .N_BUTTONS           (NB),
      .ACTIVE_LOW          (1'b1),
      .DEBOUNCE_CYCLES     (DB),
      .REPEAT_DELAY_CYCLES (DELAY),
      .REPEAT_RATE_CYCLES  (RATE),
      .REPEAT_MASK         (MASK)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (en),
      .iButton (iButton),
      .oButton (oButton),
      .oLevel  (oLevel)
   );

   // Reference model: per key, how long the synchronised level has been stable,
   // whether the key is armed, and how many cycles the current hold has lasted.
   logic [NB-1:0] exp_btn = '0;
   logic [NB-1:0] exp_lvl = '0;
   bit armed[NB];
   bit lvl[NB];
   bit h1[NB];
   bit h2[NB];
   int arm_run[NB];
   int prun[NB];
   int rrun[NB];
   int hold[NB];

   task automatic model_reset();
      for (int i = 0; i < NB; i++) begin
         armed[i] = 0; lvl[i] = 0; h1[i] = 0; h2[i] = 0;
         arm_run[i] = 0; prun[i] = 0; rrun[i] = 0; hold[i] = 0;
      end
      exp_btn = '0;
      exp_lvl = '0;
   endtask

   task automatic model_step();
      logic [NB-1:0] pul;
      bit p;
      pul = '0;
      for (int i = 0; i < NB; i++) begin
         p     = h2[i];
         h2[i] = h1[i];
         h1[i] = press[i];
         if (!en) begin
            armed[i] = 0; lvl[i] = 0; arm_run[i] = 0; prun[i] = 0; rrun[i] = 0; hold[i] = 0;
         end else if (!armed[i]) begin
            arm_run[i] = p ? 0 : arm_run[i] + 1;
            if (arm_run[i] == DB) begin
               armed[i] = 1;
               prun[i]  = 0;
            end
         end else if (!lvl[i]) begin
            prun[i] = p ? prun[i] + 1 : 0;
            if (prun[i] == DB + 1) begin
               pul[i] = 1'b1; lvl[i] = 1; hold[i] = 0; rrun[i] = 0;
            end
         end else if (!p) begin
            rrun[i] = rrun[i] + 1;
            if (rrun[i] == DB + 1) begin
               lvl[i]  = 0;
               prun[i] = 0;
            end
         end else if (rrun[i] > 0) begin
            rrun[i] = 0;
            hold[i] = 0;
         end else begin
            hold[i] = hold[i] + 1;
            if (MASK[i] && hold[i] >= DELAY && ((hold[i] - DELAY) % RATE) == 0) pul[i] = 1'b1;
         end
         exp_lvl[i] = lvl[i];
      end
      exp_btn = '0;
      for (int i = NB - 1; i >= 0; i--) begin
         if (pul[i]) exp_btn = NB'(1) << i;
      end
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) model_reset();
         else model_step();
      end
   end

   task automatic test_reset();
      rst_n = 1'b0;
      en    = 1'b1;
      press = '0;
      repeat (3) @(negedge clk);
      checks++;
      if (oButton !== '0 || oLevel !== '0) begin
         fails++;
         $display("[TB] FAIL reset_hold: oButton=%b oLevel=%b, required 0000 0000", oButton, oLevel);
      end
      rst_n = 1'b1;
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         checks++;
         if (oButton !== exp_btn || oLevel !== exp_lvl || oButton !== '0 || oLevel !== '0) begin
            fails++;
            $display("[TB] FAIL reset_release c=%0d: oButton=%b oLevel=%b, required 0000 0000", c, oButton, oLevel);
         end
      end
   endtask

   task automatic test_clean_press();
      int first = -1, npulse = 0, rise = -1, fall = -1;
      logic [NB-1:0] val = '0;
      for (int c = 1; c <= 60; c++) begin
         @(negedge clk);
         checks++;
         if (oButton !== exp_btn || oLevel !== exp_lvl) begin
            fails++;
            $display("[TB] FAIL clean_press c=%0d: oButton=%b oLevel=%b, required %b %b", c, oButton, oLevel, exp_btn, exp_lvl);
         end
         if (oButton != '0) begin
            npulse++;
            if (first < 0) begin first = c - 12; val = oButton; end
         end
         if (oLevel[2] && rise < 0) rise = c - 12;
         if (!oLevel[2] && rise >= 0 && fall < 0) fall = c - 12;
         if (c == 12) press[2] = 1'b1;
         if (c == 42) press[2] = 1'b0;
      end
      checks++;
      if (first != 7 || npulse != 1 || val !== 4'b0100) begin
         fails++;
         $display("[TB] FAIL clean_press_pulse: at t+%0d count %0d value %b, required t+7 count 1 value 0100", first, npulse, val);
      end
      checks++;
      if (rise != 7 || fall != 37) begin
         fails++;
         $display("[TB] FAIL clean_press_level: high t+%0d..t+%0d, required t+7..t+37", rise, fall);
      end
   endtask

   task automatic test_bounce();
      int npulse = 0, nlevel = 0;
      for (int c = 1; c <= 60; c++) begin
         @(negedge clk);
         checks++;
         if (oButton !== exp_btn || oLevel !== exp_lvl) begin
            fails++;
            $display("[TB] FAIL bounce c=%0d: oButton=%b oLevel=%b, required %b %b", c, oButton, oLevel, exp_btn, exp_lvl);
         end
         if (oButton != '0) npulse++;
         if (oLevel != '0) nlevel++;
         if (c >= 12 && c < 32) press[0] = ((c - 12) % 5) < 3;
         else press[0] = 1'b0;
      end
      checks++;
      if (npulse != 0 || nlevel != 0) begin
         fails++;
         $display("[TB] FAIL bounce_quiet: %0d pulses, %0d level cycles, required 0 and 0", npulse, nlevel);
      end
   endtask

   task automatic test_repeat();
      int got[$];
      int exp_q[$] = '{7, 27, 35, 43, 51, 59};
      for (int k = 0; k < 2; k++) begin
         int key = (k == 0) ? 1 : 3;
         int bad_val = 0;
         got.delete();
         for (int c = 1; c <= 90; c++) begin
            @(negedge clk);
            checks++;
            if (oButton !== exp_btn || oLevel !== exp_lvl) begin
               fails++;
               $display("[TB] FAIL repeat_key%0d c=%0d: oButton=%b oLevel=%b, required %b %b", key, c, oButton, oLevel, exp_btn, exp_lvl);
            end
            if (oButton != '0) begin
               got.push_back(c - 12);
               if (oButton !== (NB'(1) << key)) bad_val++;
            end
            if (c == 12) press[key] = 1'b1;
            if (c == 72) press[key] = 1'b0;
         end
         checks++;
         if (bad_val != 0) begin
            fails++;
            $display("[TB] FAIL repeat_value_key%0d: %0d pulses on wrong bit, required 0", key, bad_val);
         end
         if (key == 1) begin
            checks++;
            if (got.size() != exp_q.size()) begin
               fails++;
               $display("[TB] FAIL repeat_count_key1: %0d pulses, required %0d", got.size(), exp_q.size());
            end else begin
               foreach (exp_q[j]) begin
                  checks++;
                  if (got[j] != exp_q[j]) begin
                     fails++;
                     $display("[TB] FAIL repeat_time_key1[%0d]: t+%0d, required t+%0d", j, got[j], exp_q[j]);
                  end
               end
            end
         end else begin
            checks++;
            if (got.size() != 1 || got[0] != 7) begin
               fails++;
               $display("[TB] FAIL repeat_key3_single: %0d pulses (first t+%0d), required 1 at t+7", got.size(), (got.size() > 0) ? got[0] : -1);
            end
         end
      end
   endtask

   task automatic test_simultaneous();
      int npulse = 0;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         checks++;
         if (oButton !== exp_btn || oLevel !== exp_lvl) begin
            fails++;
            $display("[TB] FAIL simultaneous c=%0d: oButton=%b oLevel=%b, required %b %b", c, oButton, oLevel, exp_btn, exp_lvl);
         end
         if (oButton != '0) npulse++;
         if (c == 19) begin
            checks++;
            if (oButton !== 4'b0001 || oLevel !== 4'b0011) begin
               fails++;
               $display("[TB] FAIL simultaneous_arbiter: oButton=%b oLevel=%b, required 0001 0011", oButton, oLevel);
            end
         end
         if (c == 12) press[1:0] = 2'b11;
         if (c == 24) press[1:0] = 2'b00;
      end
      checks++;
      if (npulse != 1) begin
         fails++;
         $display("[TB] FAIL simultaneous_count: %0d pulses, required 1", npulse);
      end
   endtask

   task automatic test_held_through_reset();
      int early = 0, first = -1;
      logic [NB-1:0] val = '0;
      press[2] = 1'b1;
      repeat (10) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (oButton !== '0 || oLevel !== '0) begin
         fails++;
         $display("[TB] FAIL async_reset: oButton=%b oLevel=%b, required 0000 0000", oButton, oLevel);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int c = 1; c <= 60; c++) begin
         @(negedge clk);
         checks++;
         if (oButton !== exp_btn || oLevel !== exp_lvl) begin
            fails++;
            $display("[TB] FAIL held_reset c=%0d: oButton=%b oLevel=%b, required %b %b", c, oButton, oLevel, exp_btn, exp_lvl);
         end
         if (oButton != '0 && c < 43) early++;
         if (oButton != '0 && c >= 43 && first < 0) begin first = c; val = oButton; end
         if (c == 30) press[2] = 1'b0;
         if (c == 36) press[2] = 1'b1;
         if (c == 50) press[2] = 1'b0;
      end
      checks++;
      if (early != 0 || first != 43 || val !== 4'b0100) begin
         fails++;
         $display("[TB] FAIL held_reset_pulse: %0d early pulses, repress pulse at c=%0d value %b, required 0, c=43, 0100", early, first, val);
      end
   endtask

   task automatic test_enable();
      int quiet = 0, first = -1;
      for (int c = 1; c <= 140; c++) begin
         @(negedge clk);
         checks++;
         if (oButton !== exp_btn || oLevel !== exp_lvl) begin
            fails++;
            $display("[TB] FAIL enable c=%0d: oButton=%b oLevel=%b, required %b %b", c, oButton, oLevel, exp_btn, exp_lvl);
         end
         if (c == 47) begin
            checks++;
            if (oButton !== '0 || oLevel !== '0) begin
               fails++;
               $display("[TB] FAIL enable_drop: oButton=%b oLevel=%b, required 0000 0000", oButton, oLevel);
            end
         end
         if (c >= 47 && c < 117 && oButton != '0) quiet++;
         if (c >= 117 && oButton != '0 && first < 0) first = c;
         if (c == 12) press[1] = 1'b1;
         if (c == 46) en = 1'b0;
         if (c == 56) en = 1'b1;
         if (c == 100) press[1] = 1'b0;
         if (c == 110) press[1] = 1'b1;
         if (c == 125) press[1] = 1'b0;
      end
      checks++;
      if (quiet != 0 || first != 117) begin
         fails++;
         $display("[TB] FAIL enable_rearm: %0d pulses while held, repress pulse at c=%0d, required 0 and c=117", quiet, first);
      end
   endtask

   task automatic test_random();
      int dur[NB];
      int en_off = 0;
      int pulses = 0;
      foreach (dur[i]) dur[i] = $urandom_range(0, 10);
      for (int c = 1; c <= 2000; c++) begin
         @(negedge clk);
         checks++;
         if (oButton !== exp_btn || oLevel !== exp_lvl) begin
            fails++;
            $display("[TB] FAIL random c=%0d: oButton=%b oLevel=%b, required %b %b", c, oButton, oLevel, exp_btn, exp_lvl);
         end
         if (oButton != '0) pulses++;
         if (c == 1000) begin
            #2 rst_n = 1'b0;
            #1;
            checks++;
            if (oButton !== '0 || oLevel !== '0) begin
               fails++;
               $display("[TB] FAIL random_reset: oButton=%b oLevel=%b, required 0000 0000", oButton, oLevel);
            end
         end
         if (c == 1004) rst_n = 1'b1;
         for (int i = 0; i < NB; i++) begin
            if (dur[i] == 0) begin
               press[i] = ~press[i];
               dur[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : $urandom_range(5, 50);
            end else begin
               dur[i]--;
            end
         end
         if (en_off > 0) begin
            en_off--;
            if (en_off == 0) en = 1'b1;
         end else if ($urandom_range(0, 249) == 0) begin
            en = 1'b0;
            en_off = $urandom_range(1, 6);
         end
      end
      press = '0;
      en = 1'b1;
      $display("[TB] random traffic produced %0d output pulses", pulses);
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      test_reset();
      test_clean_press();
      test_bounce();
      test_repeat();
      test_simultaneous();
      test_held_through_reset();
      test_enable();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
